// File: rtl/rx_uart.sv
// rx_uart: oversampling UART receiver.
// Frame: start(0), INPUT_DATA_WIDTH data bits LSB first, optional even parity, stop(1).
// Timing advances only on sample_tick, which runs at OVERSAMPLE x baud.
// Optional build macro RX_MAJORITY_VOTE_EN: each bit is resolved as the 2-of-3 majority
// of samples at cnt == M-1, M and M+1. Without it, the bit is the single sample at cnt == M.
// The bit is committed at cnt == M+1 in both builds.
module rx_uart #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int OVERSAMPLE       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sample_tick,
  input  logic                        serial_in,
  output logic [INPUT_DATA_WIDTH-1:0] o_data,
  output logic                        o_valid,
  output logic                        o_parity_err,
  output logic                        o_frame_err,
  output logic                        o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;
  localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_PRE  = CW'(M - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_DEC  = CW'(M + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                      state;
  logic   [CW-1:0]             cnt;
  logic   [BW-1:0]             bit_cnt;
  logic   [INPUT_DATA_WIDTH-1:0] shreg;
  logic                        par_acc;
  logic                        par_err_q;
  logic                        stop_q;
  logic                        done;
  logic                        sync1;
  logic                        sync2;
  logic                        line_prev;
  logic                        bit_res;
  logic                        at_dec;
  logic                        at_end;

  // Two-flop synchronizer; idles high so reset does not fake a start edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= serial_in;
      sync2 <= sync1;
    end
  end

  // Previous synchronized sample, for 1->0 start-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_prev <= 1'b1;
    end else if (sample_tick) begin
      line_prev <= sync2;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic samp_pre;
  logic samp_mid;

  // Capture the two early votes; the third is the live sample at the decision tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_pre <= 1'b1;
      samp_mid <= 1'b1;
    end else if (sample_tick) begin
      if (cnt == CNT_PRE) samp_pre <= sync2;
      if (cnt == CNT_MID) samp_mid <= sync2;
    end
  end

  // 2-of-3 majority resolution
  always_comb begin
    bit_res = (samp_pre & samp_mid) | (samp_pre & sync2) | (samp_mid & sync2);
  end
`else
  logic samp_mid;

  // Capture the mid-bit sample; it is committed one tick later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_mid <= 1'b1;
    end else if (sample_tick && (cnt == CNT_MID)) begin
      samp_mid <= sync2;
    end
  end

  // Single-sample resolution
  always_comb begin
    bit_res = samp_mid;
  end
`endif

  // Decision and end-of-bit points; both may coincide when OVERSAMPLE == 4
  always_comb begin
    at_dec = (cnt == CNT_DEC);
    at_end = (cnt == CNT_LAST);
  end

  // Receive FSM plus registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_acc      <= 1'b0;
      par_err_q    <= 1'b0;
      stop_q       <= 1'b1;
      done         <= 1'b0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      done    <= 1'b0;

      // The stop decision leaves a one-clk token; results publish on the next clk
      if (done) begin
        o_valid      <= 1'b1;
        o_data       <= shreg;
        o_parity_err <= (PARITY_ENABLED != 0) ? par_err_q : 1'b0;
        o_frame_err  <= ~stop_q;
      end

      if (sample_tick) begin
        cnt <= at_end ? '0 : cnt + 1'b1;
        case (state)
          IDLE: begin
            cnt <= '0;
            if (line_prev && !sync2) begin
              state   <= START;
              par_acc <= 1'b0;
            end
          end
          START: begin
            if (at_dec && bit_res) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (at_end) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (at_dec) begin
              shreg   <= {bit_res, shreg[INPUT_DATA_WIDTH-1:1]};
              par_acc <= par_acc ^ bit_res;
            end
            if (at_end) begin
              if (bit_cnt == BIT_LAST) begin
                state <= (PARITY_ENABLED != 0) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          PARITY: begin
            if (at_dec) par_err_q <= par_acc ^ bit_res;
            if (at_end) state <= STOP;
          end
          STOP: begin
            // Leave at the decision, not at the end of the bit, so a
            // following start edge is never missed
            if (at_dec) begin
              state  <= IDLE;
              cnt    <= '0;
              done   <= 1'b1;
              stop_q <= bit_res;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart with default parameters.
// sample_tick fires every 4 clks; the serial line is driven in units of ticks.
module tb_rx_uart;

  logic       clk;
  logic       reset;
  logic       sample_tick;
  logic       serial_in;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    bit          bad_par;
    logic        stop_bit;
    int unsigned idle_after;
    logic        exp_perr;
    logic        exp_ferr;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        vecs[7];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  bit          tol = 1'b0;
  bit          tick_en = 1'b1;
  int unsigned ph = 0;

  rx_uart #(
    .INPUT_DATA_WIDTH(8),
    .PARITY_ENABLED(1),
    .OVERSAMPLE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .serial_in(serial_in),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err),
    .o_busy(o_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sample_tick: high for one clk in every four, changed just after posedge
  initial begin
    sample_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sample_tick = tick_en && (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic p, input logic f);
    exp_t e;
    e.data = d;
    e.perr = p;
    e.ferr = f;
    sb_q.push_back(e);
  endtask

  // Return 2ns after the next clk edge on which the DUT sees sample_tick
  task automatic wait_tick();
    bit          got;
    int unsigned k;
    got = 1'b0;
    k   = 0;
    while (!got) begin
      @(posedge clk);
      got = sample_tick;
      k++;
      if (!got && k > 100) begin
        n_bad++;
        $display("FAIL wait_tick: got no sample_tick in 100 clks, required one");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "tick bound expired");
      end
    end
    #2;
  endtask

  task automatic line_ticks(input logic v, input int unsigned n);
    serial_in = v;
    repeat (n) wait_tick();
  endtask

  // Bit index: 0 start, 1..8 data, 9 parity, 10 stop
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop_bit,
                            input int pause_idx, input int glitch_idx, input bit busy_chk);
    logic [10:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    bits[9]   = (^d) ^ bad_par;
    bits[10]  = stop_bit;
    for (int i = 0; i < 11; i++) begin
      if (busy_chk && i == 0) begin
        line_ticks(bits[i], 1);
        @(negedge clk);
        check("busy_after_start_edge", o_busy, 1);
        line_ticks(bits[i], 15);
      end else if (busy_chk && i == 10) begin
        line_ticks(bits[i], 10);
        @(negedge clk);
        check("busy_before_stop_decision", o_busy, 1);
        line_ticks(bits[i], 1);
        @(negedge clk);
        check("idle_after_stop_decision", o_busy, 0);
        line_ticks(bits[i], 5);
      end else if (i == glitch_idx) begin
        line_ticks(bits[i], 9);
        line_ticks(~bits[i], 1);
        line_ticks(bits[i], 6);
      end else if (i == pause_idx) begin
        line_ticks(bits[i], 8);
        tick_en = 1'b0;
        repeat (64) @(posedge clk);
        @(negedge clk);
        check("busy_frozen_without_ticks", o_busy, 1);
        tick_en = 1'b1;
        line_ticks(bits[i], 8);
      end else begin
        line_ticks(bits[i], 16);
      end
    end
  endtask

  // Output monitor: every o_valid pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b0 && o_valid === 1'b1) begin
      if (tol) begin
        check("aborted_frame_flagged", {31'b0, o_parity_err | o_frame_err}, 1);
      end else if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got o_valid with o_data=%0h, required no pulse", o_data);
      end else begin
        mon_e = sb_q.pop_front();
        check("rx_data", o_data, mon_e.data);
        check("rx_parity_err", o_parity_err, mon_e.perr);
        check("rx_frame_err", o_frame_err, mon_e.ferr);
      end
    end
  end

  initial begin
    int unsigned w;
    vecs[0] = '{8'h01, 1'b1, 1'b1, 20, 1'b1, 1'b0};
    vecs[1] = '{8'h02, 1'b0, 1'b1, 20, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 1'b0, 1'b1, 0,  1'b0, 1'b0};
    vecs[3] = '{8'h34, 1'b0, 1'b1, 20, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 0,  1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 20, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 20, 1'b1, 1'b0};

    reset     = 1'b1;
    serial_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data", o_data, 0);
    check("reset_valid", o_valid, 0);
    check("reset_parity_err", o_parity_err, 0);
    check("reset_frame_err", o_frame_err, 0);
    check("reset_busy", o_busy, 0);
    reset = 1'b0;
    line_ticks(1'b1, 4);

    // Clean frame with busy window checks
    @(negedge clk);
    check("busy_idle", o_busy, 0);
    push_exp(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1, -1, -1, 1'b1);
    line_ticks(1'b1, 10);

    // False start: 4 ticks low, aborted at the start-bit decision
    line_ticks(1'b0, 4);
    line_ticks(1'b1, 5);
    @(negedge clk);
    check("busy_in_false_start", o_busy, 1);
    line_ticks(1'b1, 3);
    @(negedge clk);
    check("false_start_back_to_idle", o_busy, 0);
    line_ticks(1'b1, 20);
    push_exp(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, -1, -1, 1'b0);
    line_ticks(1'b1, 10);

    // Table: parity errors, clearing, back-to-back frames
    for (int i = 0; i < 7; i++) begin
      push_exp(vecs[i].data, vecs[i].exp_perr, vecs[i].exp_ferr);
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop_bit, -1, -1, 1'b0);
      if (vecs[i].idle_after > 0) line_ticks(1'b1, vecs[i].idle_after);
    end

    // Framing error, line held low, then recovery
    push_exp(8'h7E, 1'b0, 1'b1);
    send_frame(8'h7E, 1'b0, 1'b0, -1, -1, 1'b0);
    line_ticks(1'b0, 40);
    @(negedge clk);
    check("no_retrigger_while_low", o_busy, 0);
    line_ticks(1'b1, 20);
    push_exp(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1, -1, -1, 1'b0);
    line_ticks(1'b1, 10);

    // sample_tick held low mid-frame freezes the receiver
    push_exp(8'h96, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b1, 5, -1, 1'b0);
    line_ticks(1'b1, 10);

    // One-tick glitch at the mid sample of data bit 2
`ifdef RX_MAJORITY_VOTE_EN
    push_exp(8'hA5, 1'b0, 1'b0);
`else
    push_exp(8'hA1, 1'b1, 1'b0);
`endif
    send_frame(8'hA5, 1'b0, 1'b1, -1, 3, 1'b0);
    line_ticks(1'b1, 10);

    // Reset in the middle of data bit 3 of 0xF0
    line_ticks(1'b0, 16);
    line_ticks(1'b0, 48);
    line_ticks(1'b0, 8);
    #1;
    reset = 1'b1;
    #3;
    check("midreset_data", o_data, 0);
    check("midreset_valid", o_valid, 0);
    check("midreset_parity_err", o_parity_err, 0);
    check("midreset_frame_err", o_frame_err, 0);
    check("midreset_busy", o_busy, 0);
    tol = 1'b1;
    #14;
    reset = 1'b0;
    line_ticks(1'b0, 8);
    line_ticks(1'b1, 64);
    line_ticks(1'b0, 16);
    line_ticks(1'b1, 16);
    line_ticks(1'b1, 200);
    tol = 1'b0;
    push_exp(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b1, -1, -1, 1'b0);
    line_ticks(1'b1, 10);

    w = 0;
    while (sb_q.size() != 0 && w < 2000) begin
      @(posedge clk);
      w++;
    end
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
